// File: rtl/controle_multiciclo.sv
// Multicycle control unit for a small RV64 subset (add/sub, addi, ld, sd,
// beq/bne, lui, jal, ebreak). A 16-state Moore FSM drives the datapath.
// Outputs are decoded from the state register, except PC_WRITE in BRANCH,
// which also depends on ZERO. Memory reads stall for MEM_WAIT cycles.
module controle_multiciclo #(
   parameter int MEM_WAIT = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [6:0] IR6_0,
   input  logic [2:0] FUNCT3,
   input  logic       FUNCT7_5,
   input  logic       ZERO,
   output logic       PC_WRITE,
   output logic       PC_SRC,
   output logic       IR_WIRE,
   output logic       LOAD_A,
   output logic       LOAD_B,
   output logic       LOAD_ALUOUT,
   output logic       LOAD_MDR,
   output logic       ALU_SRCA,
   output logic [1:0] ALU_SRCB,
   output logic [2:0] ALU_SELECTOR,
   output logic       MEM32_WIRE,
   output logic       MEM64_WIRE,
   output logic       BANCO_WIRE,
   output logic [1:0] MEM_TO_REG,
   output logic       HALTED,
   output logic       ILLEGAL,
   output logic [3:0] STATE
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,  S_IR_LOAD  = 4'd1,  S_DECODE   = 4'd2,  S_EXEC_R   = 4'd3,
      S_EXEC_I    = 4'd4,  S_MEM_ADDR = 4'd5,  S_MEM_READ = 4'd6,  S_MEM_WRITE = 4'd7,
      S_WB_ALU    = 4'd8,  S_WB_MEM   = 4'd9,  S_WB_LUI   = 4'd10, S_BRANCH   = 4'd11,
      S_JAL_LINK  = 4'd12, S_JAL_JUMP = 4'd13, S_PC_INC   = 4'd14, S_HALT     = 4'd15
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

   state_t     state_r;
   state_t     next_state_s;
   logic [3:0] wait_cnt_r;
   logic       started_r;
   logic       illegal_r;
   logic       set_illegal_s;
   logic       wait_done_s;
   logic       taken_s;

   assign wait_done_s = (wait_cnt_r == WAIT_LAST);
   assign taken_s     = ((FUNCT3 == 3'b000) && ZERO) || ((FUNCT3 == 3'b001) && !ZERO);
   assign MEM32_WIRE  = 1'b0;
   assign ILLEGAL     = illegal_r;
   assign STATE       = state_r;

   // State register, wait counter (cleared on every state change), sticky illegal flag.
   // started_r holds the FSM for the first edge after reset release so that the
   // first FETCH cycle begins on that edge.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_r    <= S_FETCH;
         wait_cnt_r <= 4'd0;
         started_r  <= 1'b0;
         illegal_r  <= 1'b0;
      end else if (!started_r) begin
         started_r  <= 1'b1;
         state_r    <= S_FETCH;
         wait_cnt_r <= 4'd0;
      end else begin
         state_r   <= next_state_s;
         illegal_r <= illegal_r | set_illegal_s;
         if (next_state_s != state_r) begin
            wait_cnt_r <= 4'd0;
         end else if ((state_r == S_FETCH) || (state_r == S_MEM_READ)) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
         end else begin
            wait_cnt_r <= 4'd0;
         end
      end
   end

   // Next-state logic and opcode dispatch; unknown encodings halt as illegal.
   always_comb begin
      next_state_s  = state_r;
      set_illegal_s = 1'b0;
      case (state_r)
         S_FETCH:    next_state_s = wait_done_s ? S_IR_LOAD : S_FETCH;
         S_IR_LOAD:  next_state_s = S_DECODE;
         S_DECODE: begin
            next_state_s  = S_HALT;
            set_illegal_s = 1'b1;
            case (IR6_0)
               7'b0110011: if (FUNCT3 == 3'b000) begin
                  next_state_s = S_EXEC_R;   set_illegal_s = 1'b0;
               end else begin
                  next_state_s = S_HALT;     set_illegal_s = 1'b1;
               end
               7'b0010011: if (FUNCT3 == 3'b000) begin
                  next_state_s = S_EXEC_I;   set_illegal_s = 1'b0;
               end else begin
                  next_state_s = S_HALT;     set_illegal_s = 1'b1;
               end
               7'b0000011, 7'b0100011: if (FUNCT3 == 3'b011) begin
                  next_state_s = S_MEM_ADDR; set_illegal_s = 1'b0;
               end else begin
                  next_state_s = S_HALT;     set_illegal_s = 1'b1;
               end
               7'b1100011: if ((FUNCT3 == 3'b000) || (FUNCT3 == 3'b001)) begin
                  next_state_s = S_BRANCH;   set_illegal_s = 1'b0;
               end else begin
                  next_state_s = S_HALT;     set_illegal_s = 1'b1;
               end
               7'b0110111: begin next_state_s = S_WB_LUI;   set_illegal_s = 1'b0; end
               7'b1101111: begin next_state_s = S_JAL_LINK; set_illegal_s = 1'b0; end
               7'b1110011: begin next_state_s = S_HALT;     set_illegal_s = 1'b0; end
               default:    begin next_state_s = S_HALT;     set_illegal_s = 1'b1; end
            endcase
         end
         S_EXEC_R:   next_state_s = S_WB_ALU;
         S_EXEC_I:   next_state_s = S_WB_ALU;
         S_MEM_ADDR: begin
            if (IR6_0 == 7'b0000011) begin
               next_state_s = S_MEM_READ;
            end else begin
               next_state_s = S_MEM_WRITE;
            end
         end
         S_MEM_READ:  next_state_s = wait_done_s ? S_WB_MEM : S_MEM_READ;
         S_MEM_WRITE: next_state_s = S_PC_INC;
         S_WB_ALU:    next_state_s = S_PC_INC;
         S_WB_MEM:    next_state_s = S_PC_INC;
         S_WB_LUI:    next_state_s = S_PC_INC;
         S_BRANCH:    next_state_s = taken_s ? S_FETCH : S_PC_INC;
         S_JAL_LINK:  next_state_s = S_JAL_JUMP;
         S_JAL_JUMP:  next_state_s = S_FETCH;
         S_PC_INC:    next_state_s = S_FETCH;
         S_HALT:      next_state_s = S_HALT;
         default:     next_state_s = S_HALT;
      endcase
   end

   // Datapath control decode: everything low unless the state drives it.
   always_comb begin
      PC_WRITE     = 1'b0;
      PC_SRC       = 1'b0;
      IR_WIRE      = 1'b0;
      LOAD_A       = 1'b0;
      LOAD_B       = 1'b0;
      LOAD_ALUOUT  = 1'b0;
      LOAD_MDR     = 1'b0;
      ALU_SRCA     = 1'b0;
      ALU_SRCB     = 2'b00;
      ALU_SELECTOR = 3'b000;
      MEM64_WIRE   = 1'b0;
      BANCO_WIRE   = 1'b0;
      MEM_TO_REG   = 2'b00;
      HALTED       = 1'b0;
      case (state_r)
         S_IR_LOAD: IR_WIRE = 1'b1;
         S_DECODE: begin
            LOAD_A = 1'b1; LOAD_B = 1'b1; LOAD_ALUOUT = 1'b1;
            ALU_SRCB = 2'b10; ALU_SELECTOR = 3'b001;
         end
         S_EXEC_R: begin
            ALU_SRCA = 1'b1; LOAD_ALUOUT = 1'b1;
            ALU_SELECTOR = FUNCT7_5 ? 3'b010 : 3'b001;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            ALU_SRCA = 1'b1; ALU_SRCB = 2'b10; ALU_SELECTOR = 3'b001; LOAD_ALUOUT = 1'b1;
         end
         S_MEM_READ:  LOAD_MDR = wait_done_s;
         S_MEM_WRITE: MEM64_WIRE = 1'b1;
         S_WB_ALU:    begin BANCO_WIRE = 1'b1; MEM_TO_REG = 2'b00; end
         S_WB_MEM:    begin BANCO_WIRE = 1'b1; MEM_TO_REG = 2'b01; end
         S_WB_LUI:    begin BANCO_WIRE = 1'b1; MEM_TO_REG = 2'b10; end
         S_BRANCH: begin
            ALU_SRCA = 1'b1; ALU_SELECTOR = 3'b010; PC_SRC = 1'b1;
            PC_WRITE = taken_s;
         end
         S_JAL_LINK: begin
            ALU_SRCB = 2'b01; ALU_SELECTOR = 3'b001; BANCO_WIRE = 1'b1; MEM_TO_REG = 2'b11;
         end
         S_JAL_JUMP: begin PC_WRITE = 1'b1; PC_SRC = 1'b1; end
         S_PC_INC: begin
            PC_WRITE = 1'b1; ALU_SRCB = 2'b01; ALU_SELECTOR = 3'b001;
         end
         S_HALT:  HALTED = 1'b1;
         default: HALTED = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed and random instructions, each
// expanded by a reference model into the expected cycle-by-cycle state trace
// and control vector. Two instances (MEM_WAIT 1 and 3) are exercised in turn.
module tb_controle_multiciclo;

   typedef struct packed {
      logic       pc_write;
      logic       pc_src;
      logic       ir_wire;
      logic       load_a;
      logic       load_b;
      logic       load_aluout;
      logic       load_mdr;
      logic       alu_srca;
      logic [1:0] alu_srcb;
      logic [2:0] alu_sel;
      logic       mem32;
      logic       mem64;
      logic       banco;
      logic [1:0] mem_to_reg;
      logic       halted;
      logic       illegal;
      logic [3:0] state;
   } outs_t;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [6:0] ir;
   logic [2:0] f3;
   logic       f7, zero;
   wire [23:0] vec_a, vec_b;
   int         checks = 0;
   int         failures = 0;
   bit         use_b = 1'b0;
   logic [6:0] ops [0:7];

   always #5 clk = ~clk;

   controle_multiciclo #(.MEM_WAIT(1)) dut_a (
      .CLK(clk), .RESET(rst_a), .IR6_0(ir), .FUNCT3(f3), .FUNCT7_5(f7), .ZERO(zero),
      .PC_WRITE(vec_a[23]), .PC_SRC(vec_a[22]), .IR_WIRE(vec_a[21]), .LOAD_A(vec_a[20]),
      .LOAD_B(vec_a[19]), .LOAD_ALUOUT(vec_a[18]), .LOAD_MDR(vec_a[17]), .ALU_SRCA(vec_a[16]),
      .ALU_SRCB(vec_a[15:14]), .ALU_SELECTOR(vec_a[13:11]), .MEM32_WIRE(vec_a[10]),
      .MEM64_WIRE(vec_a[9]), .BANCO_WIRE(vec_a[8]), .MEM_TO_REG(vec_a[7:6]),
      .HALTED(vec_a[5]), .ILLEGAL(vec_a[4]), .STATE(vec_a[3:0]));

   controle_multiciclo #(.MEM_WAIT(3)) dut_b (
      .CLK(clk), .RESET(rst_b), .IR6_0(ir), .FUNCT3(f3), .FUNCT7_5(f7), .ZERO(zero),
      .PC_WRITE(vec_b[23]), .PC_SRC(vec_b[22]), .IR_WIRE(vec_b[21]), .LOAD_A(vec_b[20]),
      .LOAD_B(vec_b[19]), .LOAD_ALUOUT(vec_b[18]), .LOAD_MDR(vec_b[17]), .ALU_SRCA(vec_b[16]),
      .ALU_SRCB(vec_b[15:14]), .ALU_SELECTOR(vec_b[13:11]), .MEM32_WIRE(vec_b[10]),
      .MEM64_WIRE(vec_b[9]), .BANCO_WIRE(vec_b[8]), .MEM_TO_REG(vec_b[7:6]),
      .HALTED(vec_b[5]), .ILLEGAL(vec_b[4]), .STATE(vec_b[3:0]));

   function automatic outs_t cur();
      return use_b ? outs_t'(vec_b) : outs_t'(vec_a);
   endfunction

   task automatic set_rst(input logic v);
      if (use_b) rst_b = v;
      else       rst_a = v;
   endtask

   task automatic check(input string tag, input outs_t obs, input outs_t exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Control vector each state must present, straight from the state table.
   function automatic outs_t exp_out(input int code, input bit last, input bit f7v,
                                     input bit tk, input bit ill);
      outs_t o;
      o = '0;
      o.state = 4'(code);
      case (code)
         1:  o.ir_wire = 1'b1;
         2:  begin o.load_a = 1'b1; o.load_b = 1'b1; o.load_aluout = 1'b1;
                   o.alu_srcb = 2'b10; o.alu_sel = 3'b001; end
         3:  begin o.alu_srca = 1'b1; o.load_aluout = 1'b1;
                   o.alu_sel = f7v ? 3'b010 : 3'b001; end
         4, 5: begin o.alu_srca = 1'b1; o.alu_srcb = 2'b10; o.alu_sel = 3'b001;
                   o.load_aluout = 1'b1; end
         6:  o.load_mdr = last;
         7:  o.mem64 = 1'b1;
         8:  o.banco = 1'b1;
         9:  begin o.banco = 1'b1; o.mem_to_reg = 2'b01; end
         10: begin o.banco = 1'b1; o.mem_to_reg = 2'b10; end
         11: begin o.alu_srca = 1'b1; o.alu_sel = 3'b010; o.pc_src = 1'b1; o.pc_write = tk; end
         12: begin o.alu_srcb = 2'b01; o.alu_sel = 3'b001; o.banco = 1'b1; o.mem_to_reg = 2'b11; end
         13: begin o.pc_write = 1'b1; o.pc_src = 1'b1; end
         14: begin o.pc_write = 1'b1; o.alu_srcb = 2'b01; o.alu_sel = 3'b001; end
         15: begin o.halted = 1'b1; o.illegal = ill; end
         default: o = '0;
      endcase
      return o;
   endfunction

   // 0 R, 1 addi, 2 ld, 3 sd, 4 branch, 5 lui, 6 jal, 7 ebreak, 8 illegal
   function automatic int classify(input logic [6:0] op, input logic [2:0] fn3);
      case (op)
         7'b0110011: return (fn3 == 3'd0) ? 0 : 8;
         7'b0010011: return (fn3 == 3'd0) ? 1 : 8;
         7'b0000011: return (fn3 == 3'd3) ? 2 : 8;
         7'b0100011: return (fn3 == 3'd3) ? 3 : 8;
         7'b1100011: return (fn3 <= 3'd1) ? 4 : 8;
         7'b0110111: return 5;
         7'b1101111: return 6;
         7'b1110011: return 7;
         default:    return 8;
      endcase
   endfunction

   // Pull reset mid-cycle, confirm the outputs drop with no edge, then restart.
   task automatic reset_pulse(input string tag);
      #2;
      set_rst(1'b0);
      #1;
      check({tag, "_async"}, cur(), exp_out(0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      check({tag, "_hold"}, cur(), exp_out(0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      set_rst(1'b1);
      #1;
      check({tag, "_rel"}, cur(), exp_out(0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
   endtask

   // Entered at the start of a FETCH cycle; returns at the start of the next one.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] fn3, input logic f7v,
                            input logic z, input int mw, input int abort_code);
      int  codes[$];
      bit  lasts[$];
      int  cls;
      bit  tk;
      ir = op; f3 = fn3; f7 = f7v; zero = z;
      cls = classify(op, fn3);
      tk  = ((fn3 == 3'd0) && z) || ((fn3 == 3'd1) && !z);
      for (int i = 0; i < mw; i++) begin codes.push_back(0); lasts.push_back(1'b0); end
      codes.push_back(1); lasts.push_back(1'b0);
      codes.push_back(2); lasts.push_back(1'b0);
      case (cls)
         0: codes = {codes, 3, 8, 14};
         1: codes = {codes, 4, 8, 14};
         2: begin
            codes.push_back(5);
            for (int i = 0; i < mw; i++) codes.push_back(6);
            codes = {codes, 9, 14};
         end
         3: codes = {codes, 5, 7, 14};
         4: if (tk) codes.push_back(11); else codes = {codes, 11, 14};
         5: codes = {codes, 10, 14};
         6: codes = {codes, 12, 13};
         default: codes.push_back(15);
      endcase
      while (lasts.size() < codes.size()) lasts.push_back(1'b0);
      if (cls == 2) lasts[mw + 2 + mw] = 1'b1;
      foreach (codes[i]) begin
         @(negedge clk);
         check($sformatf("op%b_f%0d_z%0d_step%0d", op, fn3, z, i), cur(),
               exp_out(codes[i], lasts[i], f7v, tk, cls == 8));
         if (codes[i] == abort_code) begin
            reset_pulse("abort");
            return;
         end
         if (codes[i] == 15) begin
            for (int k = 0; k < 20; k++) begin
               @(negedge clk);
               check($sformatf("halt_hold_%0d", k), cur(), exp_out(15, 1'b0, f7v, tk, cls == 8));
            end
            reset_pulse("halt_exit");
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic run_random(input int n, input int mw);
      logic [6:0] op;
      logic [2:0] fn3;
      int         k;
      for (int j = 0; j < n; j++) begin
         k = $urandom_range(0, 8);
         op = (k == 8) ? 7'($urandom) : ops[k];
         fn3 = 3'($urandom);
         if ($urandom_range(0, 9) < 8) begin
            case (op)
               7'b0000011, 7'b0100011: fn3 = 3'd3;
               7'b1100011:             fn3 = 3'($urandom_range(0, 1));
               7'b0110011, 7'b0010011: fn3 = 3'd0;
               default:                fn3 = fn3;
            endcase
         end
         run_instr(op, fn3, 1'($urandom), 1'($urandom), mw, 99);
      end
   endtask

   initial begin
      ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
      ops[4] = 7'b1100011; ops[5] = 7'b0110111; ops[6] = 7'b1101111; ops[7] = 7'b1110011;
      rst_a = 1'b0; rst_b = 1'b0;
      ir = 7'd0; f3 = 3'd0; f7 = 1'b0; zero = 1'b0;
      #3;
      check("reset_init", cur(), exp_out(0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      rst_a = 1'b1;
      #1;
      check("reset_release", cur(), exp_out(0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;

      run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 1, 99);   // add
      run_instr(7'b0110011, 3'd0, 1'b1, 1'b1, 1, 99);   // sub
      run_instr(7'b0010011, 3'd0, 1'b0, 1'b0, 1, 99);   // addi
      run_instr(7'b0000011, 3'd3, 1'b0, 1'b0, 1, 99);   // ld
      run_instr(7'b0110111, 3'd5, 1'b0, 1'b0, 1, 99);   // lui
      run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 1, 99);   // beq taken
      run_instr(7'b1100011, 3'd0, 1'b0, 1'b0, 1, 99);   // beq not taken
      run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 1, 99);   // bne taken
      run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 1, 99);   // bne not taken
      run_instr(7'b0100011, 3'd3, 1'b0, 1'b0, 1, 99);   // sd
      run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 1, 99);   // jal
      run_instr(7'b0100011, 3'd3, 1'b0, 1'b0, 1, 7);    // reset during MEM_WRITE
      run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 1, 99);   // restart from FETCH
      run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 1, 8);    // reset during BANCO_WIRE
      run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 1, 99);   // illegal opcode
      run_instr(7'b0110011, 3'd2, 1'b0, 1'b0, 1, 99);   // illegal funct3
      run_instr(7'b1110011, 3'd0, 1'b0, 1'b0, 1, 99);   // ebreak
      run_random(60, 1);

      rst_a = 1'b0;
      use_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b1;
      #1;
      check("b_reset_release", cur(), exp_out(0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      run_instr(7'b0000011, 3'd3, 1'b0, 1'b0, 3, 99);   // ld, MEM_WAIT=3
      run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 3, 99);
      run_random(30, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, memory read wait cycles (legal 1..15) applied in FETCH and MEM_READ.
REQ-002 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-004 SHALL have inputs IR6_0 [6:0] opcode, FUNCT3 [2:0], FUNCT7_5 [0]; all from the instruction register and valid from DECODE onward.
REQ-005 SHALL have input ZERO  1  ALU equality flag, combinational in the same cycle.
REQ-006 SHALL have outputs PC_WRITE, PC_SRC (0 = ALU result, 1 = ALUOUT), IR_WIRE, LOAD_A, LOAD_B, LOAD_ALUOUT, LOAD_MDR; each 1 bit.
REQ-007 SHALL have outputs ALU_SRCA 1 (0 = PC, 1 = A), ALU_SRCB 2 (00 = B, 01 = 4, 10 = imm), ALU_SELECTOR 3 (001 add, 010 sub).
REQ-008 SHALL have outputs MEM32_WIRE 1 (tied 0), MEM64_WIRE 1 (data write), BANCO_WIRE 1, MEM_TO_REG 2 (00 ALUOUT, 01 MDR, 10 imm, 11 ALU result).
REQ-009 SHALL have outputs HALTED 1, ILLEGAL 1 and STATE [3:0], the current state code.

Function
REQ-010 SHALL be a 16-state FSM with these codes: FETCH 0, IR_LOAD 1, DECODE 2, EXEC_R 3, EXEC_I 4, MEM_ADDR 5, MEM_READ 6, MEM_WRITE 7, WB_ALU 8, WB_MEM 9, WB_LUI 10, BRANCH 11, JAL_LINK 12, JAL_JUMP 13, PC_INC 14, HALT 15.
REQ-011 SHALL drive every output to 0 in each state unless it is listed for that state; outputs are decoded from the state register only, except PC_WRITE in BRANCH.
REQ-012 FETCH and MEM_READ SHALL each last exactly MEM_WAIT cycles, using a 4-bit counter that clears on state entry.
REQ-013 Transitions: FETCH -> IR_LOAD (IR_WIRE=1) -> DECODE.
REQ-014 DECODE SHALL assert LOAD_A, LOAD_B and LOAD_ALUOUT with ALU_SRCA=0, ALU_SRCB=10 and add, so that ALUOUT = PC+imm.
REQ-015 DECODE SHALL dispatch on opcode as follows: 0110011 with funct3 000 -> EXEC_R; 0010011 with funct3 000 -> EXEC_I; 0000011 or 0100011 with funct3 011 -> MEM_ADDR; 1100011 with funct3 000/001 -> BRANCH; 0110111 -> WB_LUI; 1101111 -> JAL_LINK; 1110011 -> HALT.
REQ-016 Any other opcode/funct3 combination in DECODE SHALL go to HALT and set ILLEGAL.
REQ-017 EXEC_R SHALL drive ALU_SRCA=1, ALU_SRCB=00, ALU_SELECTOR = 010 if FUNCT7_5 else 001, and LOAD_ALUOUT, then go to WB_ALU.
REQ-018 EXEC_I SHALL drive ALU_SRCA=1, ALU_SRCB=10, add and LOAD_ALUOUT, then go to WB_ALU.
REQ-019 WB_ALU, WB_MEM and WB_LUI SHALL assert BANCO_WIRE with MEM_TO_REG 00, 01 and 10 respectively, then go to PC_INC.
REQ-020 MEM_ADDR SHALL compute A+imm into ALUOUT, then go to MEM_READ (opcode 0000011) or MEM_WRITE (opcode 0100011).
REQ-021 MEM_READ SHALL assert LOAD_MDR in its final wait cycle only, then go to WB_MEM.
REQ-022 MEM_WRITE SHALL assert MEM64_WIRE for exactly one cycle, then go to PC_INC.
REQ-023 BRANCH SHALL drive ALU_SRCA=1, ALU_SRCB=00 and sub, and is taken when (FUNCT3=000 and ZERO) or (FUNCT3=001 and !ZERO).
REQ-024 A taken branch SHALL assert PC_WRITE with PC_SRC=1 and go to FETCH; a not-taken branch SHALL go to PC_INC.
REQ-025 JAL_LINK SHALL drive PC+4 (ALU_SRCA=0, ALU_SRCB=01, add), BANCO_WIRE=1 and MEM_TO_REG=11, then go to JAL_JUMP.
REQ-026 JAL_JUMP SHALL assert PC_WRITE with PC_SRC=1, then go to FETCH.
REQ-027 PC_INC SHALL drive PC+4 with PC_WRITE=1 and PC_SRC=0, then go to FETCH.
REQ-028 HALT SHALL be absorbing: HALTED=1, all enables 0, exited only by reset.
REQ-029 ILLEGAL SHALL be sticky until reset; HALTED=1 after ebreak with ILLEGAL=0.
REQ-030 With MEM_WAIT=1, instruction latencies SHALL be: add/addi 6 cycles, ld 7, sd 6, lui 5, beq taken 4, beq not taken 5, jal 5.

Reset
REQ-031 RESET low SHALL immediately, without waiting for CLK, force state FETCH, counter 0, HALTED 0, ILLEGAL 0, and all enables 0.
REQ-032 A reset asserted mid-instruction, including during a MEM_WRITE or BANCO_WIRE cycle, SHALL drop the enable in the same instant, with no completion of the instruction.
REQ-033 After RESET rises, the first FETCH cycle SHALL begin on the next rising edge of CLK.

Verification
REQ-034 add x3,x1,x2 (0110011, f3 000, f7_5 0) -> STATE sequence 0,1,2,3,8,14,0; ALU_SELECTOR 001 in EXEC_R; BANCO_WIRE high exactly one cycle.
REQ-035 ld with MEM_WAIT=3 -> FETCH 3 cycles, MEM_READ 3 cycles, LOAD_MDR only in the third MEM_READ cycle, 11 cycles total.
REQ-036 beq with ZERO=1 -> PC_WRITE=1 and PC_SRC=1 in BRANCH, then FETCH; with ZERO=0 -> PC_INC is entered. bne with ZERO=0 -> taken (PC_WRITE=1, PC_SRC=1).
REQ-037 Opcode 1111111 -> HALT, HALTED=1, ILLEGAL=1, held for 20 cycles; then RESET low -> STATE=0 with no clock edge.
REQ-038 RESET low during MEM_WRITE -> MEM64_WIRE falls asynchronously; after release, STATE=0 and execution restarts at FETCH.
REQ-039 sd followed by jal -> MEM64_WIRE is a one-cycle pulse; in JAL_LINK, MEM_TO_REG=11 with BANCO_WIRE=1; in JAL_JUMP, PC_SRC=1.
